// File: rtl/cache_pkg.sv
// Shared definitions for the cache data array with line fill.
// Holds default geometry constants and the fill sequencer state type.
package cache_pkg;

  localparam int unsigned NUM_BLOCKS_DEF      = 128;
  localparam int unsigned WORDS_PER_BLOCK_DEF = 8;
  localparam int unsigned WORD_W_DEF          = 16;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/cache_data_block.sv
// One cache block of WORDS_PER_BLOCK words.
// Ports:
//   clk, rst  - clock and asynchronous active-high clear of all words
//   we        - per-word write enable, one bit per word
//   wdata     - write data shared by all words of the block
//   word      - read offset
//   rdata_c   - combinational read of the word at offset 'word'
module cache_data_block #(
  parameter  int unsigned WORDS_PER_BLOCK = 8,
  parameter  int unsigned WORD_W          = 16,
  localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORDS_PER_BLOCK-1:0] we,
  input  logic [WORD_W-1:0]          wdata,
  input  logic [OFF_W-1:0]           word,
  output logic [WORD_W-1:0]          rdata_c
);

  logic [WORD_W-1:0] mem [WORDS_PER_BLOCK];

  // Word storage with async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WORDS_PER_BLOCK); i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WORDS_PER_BLOCK); i++) begin
        if (we[i]) mem[i] <= wdata;
      end
    end
  end

  assign rdata_c = mem[word];

endmodule

// File: rtl/cache_data_array_fill.sv
// Cache data array with registered CPU read port and line-fill sequencer.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   cpu_en/cpu_we/cpu_blk/cpu_word - CPU access request, write select, address
//   cpu_wdata                      - CPU write data
//   cpu_ready                      - access accepted this cycle (combinational)
//   cpu_rdata/cpu_rvalid           - registered read data and its valid strobe
//   fill_start/fill_blk            - start filling a block
//   fill_valid/fill_data           - memory beat
//   fill_busy/fill_word/fill_done  - fill status, next beat offset, done pulse
module cache_data_array_fill
  import cache_pkg::*;
#(
  parameter  int unsigned NUM_BLOCKS      = NUM_BLOCKS_DEF,
  parameter  int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter  int unsigned WORD_W          = WORD_W_DEF,
  localparam int unsigned IDX_W           = $clog2(NUM_BLOCKS),
  localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [IDX_W-1:0]  cpu_blk,
  input  logic [OFF_W-1:0]  cpu_word,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              fill_start,
  input  logic [IDX_W-1:0]  fill_blk,
  input  logic              fill_valid,
  input  logic [WORD_W-1:0] fill_data,
  output logic              fill_busy,
  output logic [OFF_W-1:0]  fill_word,
  output logic              fill_done
);

  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_BLOCK - 1);

  fill_state_t       state, state_n;
  logic [IDX_W-1:0]  cur_blk, cur_blk_n;
  logic [OFF_W-1:0]  fill_word_n;
  logic              fill_done_n;

  logic              fill_wr_c;
  logic              cpu_acc_c;
  logic              cpu_wr_c;
  logic              cpu_rd_c;
  logic [WORD_W-1:0] blk_rdata_c [NUM_BLOCKS];

  // Status and access qualification; cur_blk is only meaningful while busy.
  assign fill_busy = (state == FILL);
  assign cpu_ready = ~(fill_busy && (cpu_blk == cur_blk));
  assign cpu_acc_c = cpu_en & cpu_ready;
  assign cpu_wr_c  = cpu_acc_c & cpu_we;
  assign cpu_rd_c  = cpu_acc_c & ~cpu_we;
  assign fill_wr_c = fill_busy & fill_valid;

  // Block storage with index decode. A fill beat and an accepted CPU write
  // never hit the same block, so one data mux per block is enough.
  for (genvar b = 0; b < int'(NUM_BLOCKS); b++) begin : g_blk
    logic                       fill_hit;
    logic                       cpu_hit;
    logic [WORDS_PER_BLOCK-1:0] we;
    logic [WORD_W-1:0]          wdata;

    assign fill_hit = fill_wr_c && (cur_blk == IDX_W'(b));
    assign cpu_hit  = cpu_wr_c && (cpu_blk == IDX_W'(b));
    assign wdata    = fill_hit ? fill_data : cpu_wdata;

    always_comb begin
      we = '0;
      for (int w = 0; w < int'(WORDS_PER_BLOCK); w++) begin
        we[w] = (fill_hit && (fill_word == OFF_W'(w))) ||
                (cpu_hit && (cpu_word == OFF_W'(w)));
      end
    end

    cache_data_block #(
      .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
      .WORD_W         (WORD_W)
    ) u_block (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .wdata  (wdata),
      .word   (cpu_word),
      .rdata_c(blk_rdata_c[b])
    );
  end

  // Registered read port; sampling pre-edge contents gives read-before-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata  <= '0;
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_rd_c;
      if (cpu_rd_c) cpu_rdata <= blk_rdata_c[cpu_blk];
    end
  end

  // Fill sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur_blk   <= '0;
      fill_word <= '0;
      fill_done <= 1'b0;
    end else begin
      state     <= state_n;
      cur_blk   <= cur_blk_n;
      fill_word <= fill_word_n;
      fill_done <= fill_done_n;
    end
  end

  // Fill sequencer next state.
  always_comb begin
    state_n     = state;
    cur_blk_n   = cur_blk;
    fill_word_n = fill_word;
    fill_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (fill_start) begin
          state_n     = FILL;
          cur_blk_n   = fill_blk;
          fill_word_n = '0;
        end
      end
      FILL: begin
        if (fill_valid) begin
          fill_word_n = fill_word + OFF_W'(1);
          if (fill_word == LAST_WORD) begin
            state_n     = IDLE;
            fill_done_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_data_array_fill.sv
// Self-checking bench for cache_data_array_fill: default geometry plus a
// small 4x2x8 instance. Expected read data comes from a bench-side model and
// is queued when a read is issued, then popped when cpu_rvalid appears.
module tb_cache_data_array_fill;

  localparam int unsigned NB = 128;
  localparam int unsigned WB = 8;
  localparam int unsigned WW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_en, cpu_we;
  logic [6:0]    cpu_blk;
  logic [2:0]    cpu_word;
  logic [WW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic [WW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          fill_start;
  logic [6:0]    fill_blk;
  logic          fill_valid;
  logic [WW-1:0] fill_data;
  logic          fill_busy;
  logic [2:0]    fill_word;
  logic          fill_done;

  logic          s_cpu_en, s_cpu_we;
  logic [1:0]    s_cpu_blk;
  logic [0:0]    s_cpu_word;
  logic [7:0]    s_cpu_wdata;
  logic          s_cpu_ready;
  logic [7:0]    s_cpu_rdata;
  logic          s_cpu_rvalid;
  logic          s_fill_start;
  logic [1:0]    s_fill_blk;
  logic          s_fill_valid;
  logic [7:0]    s_fill_data;
  logic          s_fill_busy;
  logic [0:0]    s_fill_word;
  logic          s_fill_done;

  int            total = 0;
  int            bad   = 0;
  logic          rd_want = 1'b0;
  logic [WW-1:0] model [NB][WB];
  logic [WW-1:0] exp_q [$];

  always #5 clk = ~clk;

  cache_data_array_fill dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_blk(cpu_blk), .cpu_word(cpu_word),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .fill_start(fill_start), .fill_blk(fill_blk),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_busy(fill_busy),
    .fill_word(fill_word), .fill_done(fill_done)
  );

  cache_data_array_fill #(.NUM_BLOCKS(4), .WORDS_PER_BLOCK(2), .WORD_W(8)) dut_s (
    .clk(clk), .rst(rst),
    .cpu_en(s_cpu_en), .cpu_we(s_cpu_we), .cpu_blk(s_cpu_blk), .cpu_word(s_cpu_word),
    .cpu_wdata(s_cpu_wdata), .cpu_ready(s_cpu_ready), .cpu_rdata(s_cpu_rdata),
    .cpu_rvalid(s_cpu_rvalid), .fill_start(s_fill_start), .fill_blk(s_fill_blk),
    .fill_valid(s_fill_valid), .fill_data(s_fill_data), .fill_busy(s_fill_busy),
    .fill_word(s_fill_word), .fill_done(s_fill_done)
  );

  task automatic idle();
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_blk = '0; cpu_word = '0; cpu_wdata = '0;
    fill_start = 1'b0; fill_blk = '0; fill_valid = 1'b0; fill_data = '0;
    s_cpu_en = 1'b0; s_cpu_we = 1'b0; s_cpu_blk = '0; s_cpu_word = '0; s_cpu_wdata = '0;
    s_fill_start = 1'b0; s_fill_blk = '0; s_fill_valid = 1'b0; s_fill_data = '0;
  endtask

  task automatic clear_model();
    for (int b = 0; b < int'(NB); b++)
      for (int w = 0; w < int'(WB); w++) model[b][w] = '0;
  endtask

  // One clock; scoreboard pops the expected read result when one is due.
  task automatic tick();
    logic          want;
    logic [WW-1:0] e;
    want = rd_want;
    rd_want = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (cpu_rvalid !== want) begin
      bad++;
      $display("FAIL rvalid: got %b want %b", cpu_rvalid, want);
    end
    if (want) begin
      e = exp_q.pop_front();
      total++;
      if (cpu_rdata !== e) begin
        bad++;
        $display("FAIL rdata: got %h want %h", cpu_rdata, e);
      end
    end
    idle();
  endtask

  task automatic cpu_read(input int b, input int w, input bit acc);
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_blk = 7'(b); cpu_word = 3'(w);
    if (acc) begin
      exp_q.push_back(model[b][w]);
      rd_want = 1'b1;
    end
  endtask

  task automatic cpu_write(input int b, input int w, input logic [WW-1:0] d);
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_blk = 7'(b); cpu_word = 3'(w); cpu_wdata = d;
    model[b][w] = d;
  endtask

  task automatic beat(input int b, input int w, input logic [WW-1:0] d);
    fill_valid = 1'b1; fill_data = d;
    model[b][w] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_model();
    tick(); tick();
    rst = 1'b0;
    tick();
    cpu_write(5, 3, 16'h5555); tick();
    cpu_read(5, 3, 1'b1); tick();
    rst = 1'b1;
    #1;
    total++;
    if (cpu_rdata !== 16'h0 || cpu_rvalid !== 1'b0 || fill_busy !== 1'b0 ||
        fill_word !== 3'd0 || fill_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: rdata=%h rvalid=%b busy=%b word=%0d done=%b want 0000 0 0 0 0",
               cpu_rdata, cpu_rvalid, fill_busy, fill_word, fill_done);
    end
    clear_model();
    tick();
    rst = 1'b0;
    tick();
    cpu_read(5, 3, 1'b1); tick();
  endtask

  task automatic test_cpu_rw();
    cpu_write(127, 7, 16'hBEEF); tick();
    cpu_read(127, 7, 1'b1); tick();
    cpu_read(127, 7, 1'b1); tick();
    cpu_write(127, 7, 16'h1234); tick();
    cpu_read(127, 7, 1'b1); tick();
    cpu_read(127, 6, 1'b1); tick();
  endtask

  task automatic test_fill();
    int dones = 0;
    fill_start = 1'b1; fill_blk = 7'd10; tick();
    total++;
    if (fill_busy !== 1'b1 || fill_word !== 3'd0) begin
      bad++;
      $display("FAIL fill_start: busy=%b word=%0d want 1 0", fill_busy, fill_word);
    end
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1) begin
        tick();
        total++;
        if (fill_word !== 3'(i) || fill_busy !== 1'b1) begin
          bad++;
          $display("FAIL fill_gap: word=%0d busy=%b want %0d 1", fill_word, fill_busy, i);
        end
      end
      beat(10, i, 16'(32'h1000 + i)); tick();
      if (fill_done === 1'b1) dones++;
      total++;
      if (fill_word !== 3'(i + 1) || fill_busy !== (i != 7) || fill_done !== (i == 7)) begin
        bad++;
        $display("FAIL fill_beat%0d: word=%0d busy=%b done=%b want %0d %b %b",
                 i, fill_word, fill_busy, fill_done, (i + 1) % 8, i != 7, i == 7);
      end
    end
    tick();
    if (fill_done === 1'b1) dones++;
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL fill_done_count: got %0d want 1", dones);
    end
    fill_valid = 1'b1; fill_data = 16'hDEAD; tick();
    total++;
    if (fill_word !== 3'd0 || fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_beat: word=%0d busy=%b want 0 0", fill_word, fill_busy);
    end
    for (int i = 0; i < 8; i++) begin
      cpu_read(10, i, 1'b1); tick();
    end
  endtask

  task automatic test_stall();
    cpu_write(20, 0, 16'h0B0B); tick();
    // fill_start with same-cycle beat and same-cycle CPU read of the target block
    fill_start = 1'b1; fill_blk = 7'd10; fill_valid = 1'b1; fill_data = 16'hFFFF;
    cpu_read(10, 5, 1'b1);
    #1;
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_ready: got %b want 1", cpu_ready);
    end
    tick();
    total++;
    if (fill_word !== 3'd0 || fill_busy !== 1'b1) begin
      bad++;
      $display("FAIL start_beat_ignored: word=%0d busy=%b want 0 1", fill_word, fill_busy);
    end
    cpu_read(10, 3, 1'b0);
    #1;
    total++;
    if (cpu_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_ready: got %b want 0", cpu_ready);
    end
    tick();
    beat(10, 0, 16'h2000);
    cpu_write(11, 0, 16'hAAAA);
    #1;
    total++;
    if (cpu_ready !== 1'b1) begin
      bad++;
      $display("FAIL other_blk_ready: got %b want 1", cpu_ready);
    end
    tick();
    fill_start = 1'b1; fill_blk = 7'd20;
    beat(10, 1, 16'h2001); tick();
    total++;
    if (fill_word !== 3'd2 || fill_busy !== 1'b1) begin
      bad++;
      $display("FAIL restart_ignored: word=%0d busy=%b want 2 1", fill_word, fill_busy);
    end
    cpu_read(20, 0, 1'b1); tick();
    for (int i = 2; i < 8; i++) begin
      beat(10, i, 16'(32'h2000 + i)); tick();
    end
    total++;
    if (fill_done !== 1'b1 || fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_fill_done: done=%b busy=%b want 1 0", fill_done, fill_busy);
    end
    cpu_read(11, 0, 1'b1); tick();
    cpu_read(20, 0, 1'b1); tick();
    cpu_read(20, 1, 1'b1); tick();
    for (int i = 0; i < 8; i++) begin
      cpu_read(10, i, 1'b1); tick();
    end
  endtask

  task automatic test_reset_mid_fill();
    fill_start = 1'b1; fill_blk = 7'd3; tick();
    for (int i = 0; i < 4; i++) begin
      beat(3, i, 16'(32'h0F00 + i)); tick();
    end
    rst = 1'b1;
    #1;
    total++;
    if (fill_busy !== 1'b0 || fill_word !== 3'd0) begin
      bad++;
      $display("FAIL midfill_reset: busy=%b word=%0d want 0 0", fill_busy, fill_word);
    end
    clear_model();
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (fill_done !== 1'b0 || fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL midfill_no_done: done=%b busy=%b want 0 0", fill_done, fill_busy);
    end
    for (int i = 0; i < 8; i++) begin
      cpu_read(3, i, 1'b1); tick();
    end
    fill_start = 1'b1; fill_blk = 7'd3; tick();
    for (int i = 0; i < 8; i++) begin
      beat(3, i, 16'(32'h3000 + i)); tick();
    end
    total++;
    if (fill_done !== 1'b1) begin
      bad++;
      $display("FAIL refill_done: got %b want 1", fill_done);
    end
    cpu_read(3, 0, 1'b1); tick();
    cpu_read(3, 7, 1'b1); tick();
  endtask

  task automatic test_small_config();
    s_fill_start = 1'b1; s_fill_blk = 2'd2; tick();
    total++;
    if (s_fill_busy !== 1'b1 || s_fill_word !== 1'b0) begin
      bad++;
      $display("FAIL small_start: busy=%b word=%0d want 1 0", s_fill_busy, s_fill_word);
    end
    s_cpu_en = 1'b1; s_cpu_blk = 2'd2; s_cpu_word = 1'b0;
    s_fill_valid = 1'b1; s_fill_data = 8'hA1;
    #1;
    total++;
    if (s_cpu_ready !== 1'b0) begin
      bad++;
      $display("FAIL small_stall: ready=%b want 0", s_cpu_ready);
    end
    tick();
    total++;
    if (s_fill_word !== 1'b1 || s_cpu_rvalid !== 1'b0 || s_fill_done !== 1'b0) begin
      bad++;
      $display("FAIL small_beat0: word=%0d rvalid=%b done=%b want 1 0 0",
               s_fill_word, s_cpu_rvalid, s_fill_done);
    end
    s_fill_valid = 1'b1; s_fill_data = 8'hB2; tick();
    total++;
    if (s_fill_word !== 1'b0 || s_fill_done !== 1'b1 || s_fill_busy !== 1'b0) begin
      bad++;
      $display("FAIL small_wrap: word=%0d done=%b busy=%b want 0 1 0",
               s_fill_word, s_fill_done, s_fill_busy);
    end
    s_cpu_en = 1'b1; s_cpu_blk = 2'd2; s_cpu_word = 1'b1; tick();
    total++;
    if (s_cpu_rvalid !== 1'b1 || s_cpu_rdata !== 8'hB2 || s_fill_done !== 1'b0) begin
      bad++;
      $display("FAIL small_read1: rvalid=%b rdata=%h done=%b want 1 b2 0",
               s_cpu_rvalid, s_cpu_rdata, s_fill_done);
    end
    s_cpu_en = 1'b1; s_cpu_blk = 2'd2; s_cpu_word = 1'b0; tick();
    total++;
    if (s_cpu_rvalid !== 1'b1 || s_cpu_rdata !== 8'hA1) begin
      bad++;
      $display("FAIL small_read0: rvalid=%b rdata=%h want 1 a1", s_cpu_rvalid, s_cpu_rdata);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_cpu_rw();
    test_fill();
    test_stall();
    test_reset_mid_fill();
    test_small_config();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
